spu32_cpu_div_arbiter: RTL and testbench

//  Shares one spu32_cpu_div instance between two requesters (port 0: CPU core, port 1: coprocessor/accelerator).

---
 rtl/spu32_cpu_div_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_spu32_cpu_div_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/spu32_cpu_div_arbiter.sv
// Shares one spu32_cpu_div between a CPU port (0) and a coprocessor port (1).
// Operands are held in registers for the whole division; a one-entry cache answers repeats.
module spu32_cpu_div_arbiter #(
    parameter bit CACHE_EN   = 1'b1,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        I_clk,
    input  logic        I_reset_n,
    input  logic        I_req0,
    input  logic        I_req1,
    input  logic [31:0] I_dividend0,
    input  logic [31:0] I_dividend1,
    input  logic [31:0] I_divisor0,
    input  logic [31:0] I_divisor1,
    input  logic        I_divide0,
    input  logic        I_divide1,
    input  logic        I_signed0,
    input  logic        I_signed1,
    output logic        O_ack0,
    output logic        O_ack1,
    output logic [31:0] O_result,
    input  logic        I_flush,
    output logic        O_div_en,
    output logic [31:0] O_div_dividend,
    output logic [31:0] O_div_divisor,
    output logic        O_div_divide,
    output logic        O_div_signed,
    output logic        O_div_reset,
    input  logic [31:0] I_div_result,
    input  logic        I_div_busy,
    output logic [1:0]  O_dbg_state
);

    // Handshake: a port raises I_reqN with operands stable and holds it until O_ackN
    // pulses for one cycle (O_result valid in that cycle). The requester drops req at the
    // edge that samples ack; a req still high after that edge is a new request.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        rr_q, rr_d;
    logic [31:0] result_q, result_d;
    logic [31:0] dividend_q, dividend_d;
    logic [31:0] divisor_q, divisor_d;
    logic        divide_q, divide_d;
    logic        signed_q, signed_d;
    logic        cvalid_q, cvalid_d;
    logic [31:0] cdividend_q, cdividend_d;
    logic [31:0] cdivisor_q, cdivisor_d;
    logic        cdivide_q, cdivide_d;
    logic        csigned_q, csigned_d;
    logic [31:0] cresult_q, cresult_d;

    logic        req_any;
    logic        pick1;
    logic [31:0] sel_dividend;
    logic [31:0] sel_divisor;
    logic        sel_divide;
    logic        sel_signed;
    logic        cache_hit;

    // Arbitration and cache lookup on the would-be winner
    always_comb begin
        req_any = I_req0 | I_req1;
        pick1   = 1'b0;
        if (I_req0 && I_req1) begin
            pick1 = FIXED_PRIO ? 1'b0 : rr_q;
        end else begin
            pick1 = I_req1;
        end
        sel_dividend = pick1 ? I_dividend1 : I_dividend0;
        sel_divisor  = pick1 ? I_divisor1  : I_divisor0;
        sel_divide   = pick1 ? I_divide1   : I_divide0;
        sel_signed   = pick1 ? I_signed1   : I_signed0;
        // A flush in the same cycle forces a miss
        cache_hit = CACHE_EN && cvalid_q && !I_flush &&
                    (cdividend_q == sel_dividend) && (cdivisor_q == sel_divisor) &&
                    (cdivide_q == sel_divide) && (csigned_q == sel_signed);
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    if (cache_hit) begin
                        state_d = S_RESP;
                    end else if (!I_div_busy) begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT:   if (!I_div_busy) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant_d     = grant_q;
        rr_d        = rr_q;
        result_d    = result_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        divide_d    = divide_q;
        signed_d    = signed_q;
        cvalid_d    = cvalid_q & ~I_flush;
        cdividend_d = cdividend_q;
        cdivisor_d  = cdivisor_q;
        cdivide_d   = cdivide_q;
        csigned_d   = csigned_q;
        cresult_d   = cresult_q;
        case (state_q)
            S_IDLE: begin
                if (req_any && (cache_hit || !I_div_busy)) begin
                    grant_d    = pick1;
                    dividend_d = sel_dividend;
                    divisor_d  = sel_divisor;
                    divide_d   = sel_divide;
                    signed_d   = sel_signed;
                    if (cache_hit) result_d = cresult_q;
                end
            end
            S_WAIT: begin
                if (!I_div_busy) begin
                    result_d = I_div_result;
                    if (CACHE_EN) begin
                        cvalid_d    = ~I_flush;
                        cdividend_d = dividend_q;
                        cdivisor_d  = divisor_q;
                        cdivide_d   = divide_q;
                        csigned_d   = signed_q;
                        cresult_d   = I_div_result;
                    end
                end
            end
            S_RESP: rr_d = ~grant_q;
            default: ;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            grant_q     <= 1'b0;
            rr_q        <= 1'b0;
            result_q    <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            divide_q    <= 1'b0;
            signed_q    <= 1'b0;
            cvalid_q    <= 1'b0;
            cdividend_q <= '0;
            cdivisor_q  <= '0;
            cdivide_q   <= 1'b0;
            csigned_q   <= 1'b0;
            cresult_q   <= '0;
        end else begin
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            result_q    <= result_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            divide_q    <= divide_d;
            signed_q    <= signed_d;
            cvalid_q    <= cvalid_d;
            cdividend_q <= cdividend_d;
            cdivisor_q  <= cdivisor_d;
            cdivide_q   <= cdivide_d;
            csigned_q   <= csigned_d;
            cresult_q   <= cresult_d;
        end
    end

    // The divider re-samples en whenever it is idle, so en is a single-cycle pulse
    always_comb begin
        O_div_en       = (state_q == S_LAUNCH);
        O_ack0         = (state_q == S_RESP) && !grant_q;
        O_ack1         = (state_q == S_RESP) && grant_q;
        O_result       = result_q;
        O_div_dividend = dividend_q;
        O_div_divisor  = divisor_q;
        O_div_divide   = divide_q;
        O_div_signed   = signed_q;
        O_div_reset    = ~I_reset_n;
        O_dbg_state    = state_q;
    end

endmodule

// File: tb/tb_spu32_cpu_div_arbiter.sv
// Directed bench for spu32_cpu_div_arbiter with a behavioural stand-in for spu32_cpu_div
// (busy for 33 cycles after the en cycle, RISC-V divide semantics).
module tb_spu32_cpu_div_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1;
    logic [31:0] dividend0, dividend1, divisor0, divisor1;
    logic        divide0, divide1, signed0, signed1;
    logic        ack0, ack1;
    logic [31:0] result;
    logic        flush;
    logic        div_en;
    logic [31:0] div_dividend, div_divisor;
    logic        div_divide, div_signed, div_reset;
    logic [31:0] div_result;
    logic        div_busy;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;

    spu32_cpu_div_arbiter dut (
        .I_clk(clk), .I_reset_n(rst_n),
        .I_req0(req0), .I_req1(req1),
        .I_dividend0(dividend0), .I_dividend1(dividend1),
        .I_divisor0(divisor0), .I_divisor1(divisor1),
        .I_divide0(divide0), .I_divide1(divide1),
        .I_signed0(signed0), .I_signed1(signed1),
        .O_ack0(ack0), .O_ack1(ack1), .O_result(result),
        .I_flush(flush),
        .O_div_en(div_en), .O_div_dividend(div_dividend), .O_div_divisor(div_divisor),
        .O_div_divide(div_divide), .O_div_signed(div_signed), .O_div_reset(div_reset),
        .I_div_result(div_result), .I_div_busy(div_busy),
        .O_dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- divider stand-in ----------------
    function automatic logic [31:0] div_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic dv, input logic sg);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return dv ? 32'hFFFFFFFF : a;
        if (sg) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return dv ? a : 32'd0;
            return dv ? sa / sb : sa % sb;
        end
        return dv ? a / b : a % b;
    endfunction

    logic m_busy = 1'b0;
    int   m_cnt = 0;
    logic [31:0] m_res = 32'd0;
    assign div_busy   = m_busy;
    assign div_result = m_res;

    always @(posedge clk) begin
        if (div_reset) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_res  <= 32'd0;
        end else if (m_busy) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                m_res  <= div_ref(div_dividend, div_divisor, div_divide, div_signed);
            end
        end else if (div_en) begin
            m_busy <= 1'b1;
            m_cnt  <= 33;
        end
    end

    always @(negedge clk) if (div_en === 1'b1) en_cnt++;

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input int port, input logic [31:0] a, input logic [31:0] b,
                         input logic dv, input logic sg);
        if (port == 0) begin
            dividend0 = a; divisor0 = b; divide0 = dv; signed0 = sg; req0 = 1'b1;
        end else begin
            dividend1 = a; divisor1 = b; divide1 = dv; signed1 = sg; req1 = 1'b1;
        end
    endtask

    // Called just after an edge; the cycle it is called in is cycle 0 (grant cycle).
    task automatic wait_ack(input int port, input logic [31:0] exp, input int exp_lat,
                            input int exp_en, input int flush_cyc, input string tag);
        int cnt;
        int en0;
        logic mine, other;
        cnt = 0;
        en0 = en_cnt;
        flush = (flush_cyc == 0);
        forever begin
            @(negedge clk);
            mine  = (port == 0) ? ack0 : ack1;
            other = (port == 0) ? ack1 : ack0;
            if (mine === 1'b1) break;
            if (cnt >= 200) begin
                check({tag, "_timeout"}, 32'd0, 32'd1);
                break;
            end
            @(posedge clk);
            #1;
            cnt++;
            flush = (cnt == flush_cyc);
        end
        if (mine === 1'b1) begin
            check({tag, "_result"}, result, exp);
            check({tag, "_latency"}, cnt, exp_lat);
            check({tag, "_en_pulses"}, en_cnt - en0, exp_en);
            check({tag, "_other_ack"}, {31'd0, other}, 32'd0);
        end
        @(posedge clk);
        #1;
        if (port == 0) req0 = 1'b0; else req1 = 1'b0;
        flush = 1'b0;
    endtask

    task automatic single(input int port, input logic [31:0] a, input logic [31:0] b,
                          input logic dv, input logic sg, input logic [31:0] exp,
                          input int exp_lat, input int exp_en, input int flush_cyc,
                          input string tag);
        drive(port, a, b, dv, sg);
        wait_ack(port, exp, exp_lat, exp_en, flush_cyc, tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; flush = 1'b0;
        dividend0 = '0; dividend1 = '0; divisor0 = '0; divisor1 = '0;
        divide0 = 1'b0; divide1 = 1'b0; signed0 = 1'b0; signed1 = 1'b0;

        #2;
        check("rst_ack0", {31'd0, ack0}, 32'd0);
        check("rst_ack1", {31'd0, ack1}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_div_en", {31'd0, div_en}, 32'd0);
        check("rst_div_reset", {31'd0, div_reset}, 32'd1);
        check("rst_div_dividend", div_dividend, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("run_div_reset", {31'd0, div_reset}, 32'd0);
        @(posedge clk);
        #1;

        // 1: port0 DIVU 100/7
        single(0, 32'd100, 32'd7, 1'b1, 1'b0, 32'd14, 36, 1, -1, "t1_divu");
        check("t1_held_dividend", div_dividend, 32'd100);
        check("t1_held_divisor", div_divisor, 32'd7);

        // 2: port1 REM -7 % 2, then repeated as a cache hit
        single(1, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1, 32'hFFFFFFFF, 36, 1, -1, "t2_rem");
        single(1, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1, 32'hFFFFFFFF, 1, 0, -1, "t2_hit");

        // 3: both request with rr=0: port0 overflow DIV first, port1 next
        drive(0, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1);
        drive(1, 32'd1000, 32'd10, 1'b1, 1'b0);
        wait_ack(0, 32'h80000000, 36, 1, -1, "t3_p0_ovf");
        wait_ack(1, 32'd100, 36, 1, -1, "t3_p1");

        // 4: divide by zero on port0
        single(0, 32'd5, 32'd0, 1'b1, 1'b0, 32'hFFFFFFFF, 36, 1, -1, "t4_divu0");
        single(0, 32'd5, 32'd0, 1'b0, 1'b0, 32'd5, 36, 1, -1, "t4_remu0");
        single(0, 32'hFFFFFFF9, 32'd0, 1'b0, 1'b1, 32'hFFFFFFF9, 36, 1, -1, "t4_rem0");

        // rr now points at port1 after serving port0
        drive(0, 32'd81, 32'd9, 1'b1, 1'b0);
        drive(1, 32'd1000, 32'd10, 1'b1, 1'b0);
        wait_ack(1, 32'd100, 36, 1, -1, "rr_p1_first");
        wait_ack(0, 32'd9, 36, 1, -1, "rr_p0_second");

        // 5: flush at capture keeps the result out of the cache
        single(0, 32'd100, 32'd7, 1'b1, 1'b0, 32'd14, 36, 1, 35, "t5_flush_cap");
        single(0, 32'd100, 32'd7, 1'b1, 1'b0, 32'd14, 36, 1, -1, "t5_repeat_miss");
        single(0, 32'd100, 32'd7, 1'b1, 1'b0, 32'd14, 36, 1, 0, "t5_flush_idle");
        single(0, 32'd100, 32'd7, 1'b1, 1'b0, 32'd14, 1, 0, -1, "t5_hit");

        // 6: reset during WAIT
        drive(1, 32'd81, 32'd9, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_state", {30'd0, dbg_state}, 32'd0);
        check("t6_div_reset", {31'd0, div_reset}, 32'd1);
        check("t6_result", result, 32'd0);
        check("t6_div_dividend", div_dividend, 32'd0);
        check("t6_div_en", {31'd0, div_en}, 32'd0);
        req1 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Cache was cleared by reset, so this is a full miss
        single(0, 32'd100, 32'd7, 1'b1, 1'b0, 32'd14, 36, 1, -1, "t6_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
